// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and grant
// encodings plus the timeout counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_EXT = 1'b1
    } gnt_e;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core, external-port and memory handshake signals around the
// arbiter; master is the arbiter's view, slave the surrounding system's view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          CpuReq;
    logic          CpuWe;
    logic [AW-1:0] CpuAddr;
    logic [DW-1:0] CpuWData;
    logic [DW-1:0] CpuRData;
    logic          CpuDone;
    logic          CpuStall;

    logic          ExtReq;
    logic          ExtWe;
    logic [AW-1:0] ExtAddr;
    logic [DW-1:0] ExtWData;
    logic [DW-1:0] ExtRData;
    logic          ExtDone;

    logic          MemReq;
    logic          MemWe;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic [DW-1:0] MemRData;
    logic          MemAck;

    logic          Err;

    modport master (
        input  CpuReq, CpuWe, CpuAddr, CpuWData,
        input  ExtReq, ExtWe, ExtAddr, ExtWData,
        input  MemRData, MemAck,
        output CpuRData, CpuDone, CpuStall,
        output ExtRData, ExtDone,
        output MemReq, MemWe, MemAddr, MemWData,
        output Err
    );

    modport slave (
        output CpuReq, CpuWe, CpuAddr, CpuWData,
        output ExtReq, ExtWe, ExtAddr, ExtWData,
        output MemRData, MemAck,
        input  CpuRData, CpuDone, CpuStall,
        input  ExtRData, ExtDone,
        input  MemReq, MemWe, MemAddr, MemWData,
        input  Err
    );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Counts BUSY cycles without a memory ack; expired_o marks the enabled cycle
// on which the count reaches TIMEOUT.
module arb_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise saturating increment while enabled.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between the core and an external
// loader port, with registered handshakes and a sticky timeout error.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);

    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

    arb_state_e    state_q;
    gnt_e          gnt_q;
    gnt_e          last_gnt_q;
    gnt_e          gnt_d;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ext_rdata_q;
    logic          cpu_done_q;
    logic          ext_done_q;
    logic          err_q;

    logic          cnt_clr_s;
    logic          cnt_en_s;
    logic          cnt_expired_s;

    // Winner for the next grant: on a tie the port not served last time wins.
    always_comb begin
        gnt_d = GNT_CPU;
        if (bus.CpuReq && bus.ExtReq) begin
            gnt_d = (last_gnt_q == GNT_CPU) ? GNT_EXT : GNT_CPU;
        end else if (bus.ExtReq) begin
            gnt_d = GNT_EXT;
        end else begin
            gnt_d = GNT_CPU;
        end
    end

    assign cnt_clr_s = (state_q != ST_BUSY);
    assign cnt_en_s  = (state_q == ST_BUSY) && !bus.MemAck;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clr_s),
        .enable_i  (cnt_en_s),
        .expired_o (cnt_expired_s)
    );

    // Arbitration FSM with all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_CPU;
            last_gnt_q  <= GNT_EXT;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            ext_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cpu_done_q <= 1'b0;
            ext_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.CpuReq || bus.ExtReq) begin
                        gnt_q      <= gnt_d;
                        last_gnt_q <= gnt_d;
                        mem_req_q  <= 1'b1;
                        state_q    <= ST_BUSY;
                        if (gnt_d == GNT_EXT) begin
                            mem_we_q    <= bus.ExtWe;
                            mem_addr_q  <= bus.ExtAddr;
                            mem_wdata_q <= bus.ExtWData;
                        end else begin
                            mem_we_q    <= bus.CpuWe;
                            mem_addr_q  <= bus.CpuAddr;
                            mem_wdata_q <= bus.CpuWData;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // An ack on the final counted cycle still beats the timeout.
                    if (bus.MemAck || cnt_expired_s) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        if (!bus.MemAck) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= err_q;
                        end
                        if (gnt_q == GNT_EXT) begin
                            ext_done_q <= 1'b1;
                            if (!mem_we_q) begin
                                ext_rdata_q <= bus.MemAck ? bus.MemRData : ALL_ONES;
                            end else begin
                                ext_rdata_q <= ext_rdata_q;
                            end
                        end else begin
                            cpu_done_q <= 1'b1;
                            if (!mem_we_q) begin
                                cpu_rdata_q <= bus.MemAck ? bus.MemRData : ALL_ONES;
                            end else begin
                                cpu_rdata_q <= cpu_rdata_q;
                            end
                        end
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.MemReq   = mem_req_q;
    assign bus.MemWe    = mem_we_q;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemWData = mem_wdata_q;
    assign bus.CpuRData = cpu_rdata_q;
    assign bus.ExtRData = ext_rdata_q;
    assign bus.CpuDone  = cpu_done_q;
    assign bus.ExtDone  = ext_done_q;
    assign bus.Err      = err_q;
    assign bus.CpuStall = bus.CpuReq & ~cpu_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected
// grants/completions; monitors pop and compare as the DUT presents them.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wd;
    } gnt_t;

    typedef struct {
        bit          ext;
        logic [31:0] rd;
        bit          err;
    } done_t;

    logic clk = 1'b0;
    logic rst;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    ack_delay = 0;
    bit    stray_ack = 1'b0;
    gnt_t  grant_q[$];
    done_t done_q[$];
    logic  mem_req_prev = 1'b0;
    gnt_t  mon_g;
    done_t mon_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks ack_delay cycles after MemReq rises, data = addr ^ A5A50000.
    initial begin
        int busy_cnt;
        busy_cnt     = 0;
        bus.MemAck   = 1'b0;
        bus.MemRData = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst || !bus.MemReq) begin
                busy_cnt   = 0;
                bus.MemAck = stray_ack;
            end else begin
                busy_cnt++;
                bus.MemAck   = (ack_delay >= 0) && (busy_cnt == ack_delay + 1);
                bus.MemRData = bus.MemAddr ^ 32'hA5A5_0000;
            end
        end
    end

    // Monitor: compares each grant and each Done pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.CpuDone && bus.ExtDone) begin
                check("both_done", 32'(bus.ExtDone), 32'(1'b0));
            end
            if (bus.CpuDone || bus.ExtDone) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.CpuDone | bus.ExtDone), 32'(1'b0));
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_port", 32'(bus.ExtDone), 32'(mon_d.ext));
                    check("done_rdata", mon_d.ext ? bus.ExtRData : bus.CpuRData, mon_d.rd);
                    check("done_err", 32'(bus.Err), 32'(mon_d.err));
                end
            end
            if (bus.MemReq && !mem_req_prev) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", 32'(bus.MemReq), 32'(1'b0));
                end else begin
                    mon_g = grant_q.pop_front();
                    check("grant_addr", bus.MemAddr, mon_g.addr);
                    check("grant_we", 32'(bus.MemWe), 32'(mon_g.we));
                    if (mon_g.we) begin
                        check("grant_wdata", bus.MemWData, mon_g.wd);
                    end
                end
            end
        end
        mem_req_prev <= bus.MemReq;
    end

    task automatic drop_reqs();
        bus.CpuReq = 1'b0;
        bus.ExtReq = 1'b0;
    endtask

    task automatic run_access(input bit ext, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int delay,
                              input logic [31:0] exp_rd, input bit exp_err,
                              input bit drop_early, input int exp_done_at,
                              output int mreq_n);
        int done_at;
        done_at   = -1;
        mreq_n    = 0;
        ack_delay = delay;
        grant_q.push_back('{addr: addr, we: we, wd: wdata});
        done_q.push_back('{ext: ext, rd: exp_rd, err: exp_err});
        @(posedge clk);
        #1;
        if (ext) begin
            bus.ExtReq = 1'b1; bus.ExtWe = we; bus.ExtAddr = addr; bus.ExtWData = wdata;
        end else begin
            bus.CpuReq = 1'b1; bus.CpuWe = we; bus.CpuAddr = addr; bus.CpuWData = wdata;
        end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.MemReq) mreq_n++;
            if (ext ? bus.ExtDone : bus.CpuDone) begin
                done_at = n;
                break;
            end
            if (!ext && !drop_early) check("cpu_stall_pending", 32'(bus.CpuStall), 32'(1'b1));
            if (drop_early && n == 1) drop_reqs();
        end
        if (!ext && !drop_early) check("cpu_stall_at_done", 32'(bus.CpuStall), 32'(1'b0));
        drop_reqs();
        check("done_latency", 32'(done_at), 32'(exp_done_at));
    endtask

    initial begin
        int cnt;
        int mreq_n;
        rst = 1'b0;
        bus.CpuReq = 1'b0; bus.CpuWe = 1'b0; bus.CpuAddr = 32'h0; bus.CpuWData = 32'h0;
        bus.ExtReq = 1'b0; bus.ExtWe = 1'b0; bus.ExtAddr = 32'h0; bus.ExtWData = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_memreq", 32'(bus.MemReq), 32'(1'b0));
        check("rst_memwe", 32'(bus.MemWe), 32'(1'b0));
        check("rst_memaddr", bus.MemAddr, 32'h0);
        check("rst_cpudone", 32'(bus.CpuDone), 32'(1'b0));
        check("rst_extdone", 32'(bus.ExtDone), 32'(1'b0));
        check("rst_err", 32'(bus.Err), 32'(1'b0));
        check("rst_cpurdata", bus.CpuRData, 32'h0);
        check("rst_extrdata", bus.ExtRData, 32'h0);
        check("rst_stall", 32'(bus.CpuStall), 32'(1'b0));
        rst = 1'b1;

        // Tie from reset: grants must alternate CPU, EXT, CPU, EXT.
        ack_delay = 1;
        grant_q.push_back('{addr: 32'h200, we: 1'b0, wd: 32'h0});
        grant_q.push_back('{addr: 32'h300, we: 1'b0, wd: 32'h0});
        grant_q.push_back('{addr: 32'h200, we: 1'b0, wd: 32'h0});
        grant_q.push_back('{addr: 32'h300, we: 1'b0, wd: 32'h0});
        done_q.push_back('{ext: 1'b0, rd: 32'hA5A5_0200, err: 1'b0});
        done_q.push_back('{ext: 1'b1, rd: 32'hA5A5_0300, err: 1'b0});
        done_q.push_back('{ext: 1'b0, rd: 32'hA5A5_0200, err: 1'b0});
        done_q.push_back('{ext: 1'b1, rd: 32'hA5A5_0300, err: 1'b0});
        @(posedge clk);
        #1;
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 32'h200;
        bus.ExtReq = 1'b1; bus.ExtWe = 1'b0; bus.ExtAddr = 32'h300;
        cnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.CpuDone || bus.ExtDone) cnt++;
            if (cnt == 4) break;
        end
        drop_reqs();
        check("tie_done_count", 32'(cnt), 32'd4);

        // Core read of 0x40, ack two cycles after MemReq.
        run_access(1'b0, 1'b0, 32'h40, 32'h0, 2, 32'hA5A5_0040, 1'b0, 1'b0, 4, mreq_n);

        // External write with immediate ack; ExtRData keeps the last read.
        run_access(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 32'hA5A5_0300, 1'b0, 1'b0, 2, mreq_n);
        check("ext_rdata_hold", bus.ExtRData, 32'hA5A5_0300);

        // Stray MemAck while idle must do nothing.
        stray_ack = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("stray_ack_memreq", 32'(bus.MemReq), 32'(1'b0));
        end
        stray_ack = 1'b0;
        @(negedge clk);

        // Core drops its request during BUSY; exactly one Done, no re-grant.
        run_access(1'b0, 1'b0, 32'h180, 32'h0, 3, 32'hA5A5_0180, 1'b0, 1'b1, 5, mreq_n);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("no_regrant", 32'(bus.MemReq), 32'(1'b0));
        end

        // No ack at all: abort after 15 BUSY cycles with sticky Err.
        run_access(1'b0, 1'b0, 32'h80, 32'h0, -1, 32'hFFFF_FFFF, 1'b1, 1'b0, 16, mreq_n);
        check("timeout_busy_cycles", 32'(mreq_n), 32'd15);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(bus.Err), 32'(1'b1));
        check("timeout_rdata_hold", bus.CpuRData, 32'hFFFF_FFFF);

        // Reset in mid-BUSY drops MemReq at once and the access never completes.
        ack_delay = -1;
        grant_q.push_back('{addr: 32'h140, we: 1'b0, wd: 32'h0});
        @(posedge clk);
        #1;
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 32'h140;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(bus.MemReq), 32'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_memreq", 32'(bus.MemReq), 32'(1'b0));
        check("mid_rst_err", 32'(bus.Err), 32'(1'b0));
        check("mid_rst_cpurdata", bus.CpuRData, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(bus.CpuDone), 32'(1'b0));
        end
        ack_delay = 2;
        grant_q.push_back('{addr: 32'h140, we: 1'b0, wd: 32'h0});
        done_q.push_back('{ext: 1'b0, rd: 32'hA5A5_0140, err: 1'b0});
        rst = 1'b1;
        cnt = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.CpuDone) begin
                cnt = n;
                break;
            end
        end
        drop_reqs();
        check("post_rst_done_latency", 32'(cnt), 32'd3);
        repeat (4) @(negedge clk);

        check("grant_q_empty", 32'(grant_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global bound so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
